stopwatch_ctrl: RTL

//  Control FSM for the stopwatch. Conditions the raw push-buttons and the quick-mode switch:
//  2-FF synchroniser, then debounce, then one-cycle press pulses.

---
 rtl/stopwatch_ctrl_if.sv | 20 ++
 rtl/stopwatch_ctrl.sv | 69 ++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: raw button/switch inputs and divider/counter controls of the stopwatch controller
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       quick_sw;
    logic       run_en;
    logic       quick;
    logic       cnt_clear;
    logic       disp_freeze;
    logic [1:0] state;
    modport master (
        output btn_start, btn_clear, btn_lap, quick_sw,
        input  run_en, quick, cnt_clear, disp_freeze, state
    );
    modport slave (
        input  btn_start, btn_clear, btn_lap, quick_sw,
        output run_en, quick, cnt_clear, disp_freeze, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: synchronise and debounce the buttons, then run the IDLE/RUN/PAUSE/LAP control FSM
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input logic             clk,
    input logic             rst,
    stopwatch_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
    state_t          state_q, state_d;
    logic [3:0]      raw, sync1, sync2, lvl;
    logic [2:0]      lvl_q, press;
    logic [DB_W-1:0] cnt [4];
    logic            clr_d, clr_q;
    // channel order: 0 start, 1 clear, 2 lap, 3 quick switch
    assign raw   = {io.quick_sw, io.btn_lap, io.btn_clear, io.btn_start};
    assign press = lvl[2:0] & ~lvl_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_q <= lvl[2:0];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    lvl[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end
    // clear outranks start, start outranks lap; an illegal higher press lets a lower one act
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (press[1] && (state_q == IDLE || state_q == PAUSE)) begin
            state_d = IDLE;
            clr_d   = 1'b1;
        end else if (press[0]) begin
            state_d = (state_q == RUN || state_q == LAP) ? PAUSE : RUN;
        end else if (press[2] && (state_q == RUN || state_q == LAP)) begin
            state_d = (state_q == RUN) ? LAP : RUN;
        end
    end
    assign io.run_en      = state_q == RUN || state_q == LAP;
    assign io.disp_freeze = state_q == LAP;
    assign io.state       = state_q;
    assign io.quick       = lvl[3];
    assign io.cnt_clear   = clr_q;
endmodule
